// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller:
// FSM state encoding, register index width default and the bubble instruction.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DROP     = 2'd2
  } state_t;

  localparam int REG_IDX_W_DEF = 5;

  // addi x0, x0, 0 -- what a flushed stage register carries (with pc 0)
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator: the ID instruction reads a register that the load
// currently in EX has not produced yet. Register 0 never hazards.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_IDX_W = REG_IDX_W_DEF
) (
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_is_load,
  output logic                 lu_stall
);

  logic rd_live;

  assign rd_live  = ex_is_load && (ex_rd != '0);
  assign lu_stall = rd_live && ((id_rs1_used && (id_rs1 == ex_rd)) ||
                                (id_rs2_used && (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: Mealy stage enables/flushes for a 5-stage
// core, wrong-path fetch tracking and saturating stall/flush counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 32,
  parameter int REG_IDX_W = REG_IDX_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_is_load,
  input  logic                 ex_redirect,
  input  logic                 imem_busy,
  input  logic                 imem_valid,
  input  logic                 dmem_wait,
  output logic                 pc_wen,
  output logic                 if_id_wen,
  output logic                 id_ex_wen,
  output logic                 ex_mem_wen,
  output logic                 mem_wb_wen,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 mem_wb_flush,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  state_t state, state_nxt;
  logic   lu_stall;
  logic   redirect_taken;

  hazard_detect #(.REG_IDX_W(REG_IDX_W)) u_hazard (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_rd       (ex_rd),
    .ex_is_load  (ex_is_load),
    .lu_stall    (lu_stall)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= RUN;
    else      state <= state_nxt;
  end

  always_comb begin
    pc_wen         = 1'b1;
    if_id_wen      = 1'b1;
    id_ex_wen      = 1'b1;
    ex_mem_wen     = 1'b1;
    mem_wb_wen     = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    mem_wb_flush   = 1'b0;
    redirect_taken = 1'b0;
    state_nxt      = state;

    if (!rst) begin
      pc_wen       = 1'b0;
      if_id_wen    = 1'b0;
      id_ex_wen    = 1'b0;
      ex_mem_wen   = 1'b0;
      mem_wb_wen   = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
      state_nxt    = RUN;
    end else if (dmem_wait) begin
      // Freeze everything; MEM_WB takes a bubble so WB does not repeat.
      pc_wen       = 1'b0;
      if_id_wen    = 1'b0;
      id_ex_wen    = 1'b0;
      ex_mem_wen   = 1'b0;
      mem_wb_flush = 1'b1;
      if (state == DROP) state_nxt = imem_valid ? MEM_WAIT : DROP;
      else               state_nxt = MEM_WAIT;
    end else if (ex_redirect) begin
      if_id_flush    = 1'b1;
      id_ex_flush    = 1'b1;
      redirect_taken = 1'b1;
      if (state == DROP || (imem_busy && !imem_valid)) state_nxt = DROP;
      else                                             state_nxt = RUN;
    end else if (state == DROP) begin
      // Wrong-path response is dropped; its arrival releases the new fetch.
      if_id_flush = 1'b1;
      pc_wen      = imem_valid;
      state_nxt   = imem_valid ? RUN : DROP;
    end else if (lu_stall) begin
      pc_wen      = 1'b0;
      if_id_wen   = 1'b0;
      id_ex_flush = 1'b1;
      state_nxt   = RUN;
    end else if (!imem_valid) begin
      pc_wen      = 1'b0;
      if_id_flush = 1'b1;
      state_nxt   = RUN;
    end else begin
      state_nxt = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_wen && (stall_cnt != '1))        stall_cnt <= stall_cnt + 1'b1;
      if (redirect_taken && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hazards, redirects, DROP, MEM_WAIT, reset and
// counter saturation (a second 4-bit-counter instance shares the stimulus).
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_rs1_used, id_rs2_used, ex_is_load, ex_redirect;
  logic       imem_busy, imem_valid, dmem_wait;

  logic        pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen;
  logic        if_id_flush, id_ex_flush, mem_wb_flush;
  logic [31:0] stall_cnt, flush_cnt;

  logic        pc_wen4, if_id_wen4, id_ex_wen4, ex_mem_wen4, mem_wb_wen4;
  logic        if_id_flush4, id_ex_flush4, mem_wb_flush4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  int tests = 0;
  int fails = 0;

  // {pc, if_id, id_ex, ex_mem, mem_wb wen, if_id, id_ex, mem_wb flush}
  localparam logic [7:0] C_NORMAL = 8'b11111_000;
  localparam logic [7:0] C_RESET  = 8'b00000_111;
  localparam logic [7:0] C_FREEZE = 8'b00001_001;
  localparam logic [7:0] C_LU     = 8'b00111_010;
  localparam logic [7:0] C_FSTALL = 8'b01111_100;
  localparam logic [7:0] C_REDIR  = 8'b11111_110;
  localparam logic [7:0] C_DISCRD = 8'b11111_100;

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_WIDTH(32), .REG_IDX_W(5)) u_dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_redirect(ex_redirect), .imem_busy(imem_busy),
    .imem_valid(imem_valid), .dmem_wait(dmem_wait), .pc_wen(pc_wen),
    .if_id_wen(if_id_wen), .id_ex_wen(id_ex_wen), .ex_mem_wen(ex_mem_wen),
    .mem_wb_wen(mem_wb_wen), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_flush(mem_wb_flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_ctrl #(.CNT_WIDTH(4), .REG_IDX_W(5)) u_dut4 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_redirect(ex_redirect), .imem_busy(imem_busy),
    .imem_valid(imem_valid), .dmem_wait(dmem_wait), .pc_wen(pc_wen4),
    .if_id_wen(if_id_wen4), .id_ex_wen(id_ex_wen4), .ex_mem_wen(ex_mem_wen4),
    .mem_wb_wen(mem_wb_wen4), .if_id_flush(if_id_flush4), .id_ex_flush(id_ex_flush4),
    .mem_wb_flush(mem_wb_flush4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  function automatic logic [7:0] ctrl();
    return {pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen,
            if_id_flush, id_ex_flush, mem_wb_flush};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_rd = '0; ex_is_load = 1'b0; ex_redirect = 1'b0;
    imem_busy = 1'b0; imem_valid = 1'b1; dmem_wait = 1'b0;
  endtask

  // Inputs change 1 time unit after a rising edge; Mealy outputs are read mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    tick();
    #3 chk("reset_ctrl", {24'h0, ctrl()}, {24'h0, C_RESET});
    tick();
    chk("reset_stall", stall_cnt, 32'd0);
    chk("reset_flush", flush_cnt, 32'd0);

    rst = 1'b1;
    #3 chk("normal", {24'h0, ctrl()}, {24'h0, C_NORMAL});
    tick();
    chk("normal_stall", stall_cnt, 32'd0);

    // load-use on rs1
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
    #3 chk("lu_rs1", {24'h0, ctrl()}, {24'h0, C_LU});
    tick();
    chk("lu_rs1_stall", stall_cnt, 32'd1);
    idle();
    #3 chk("lu_after", {24'h0, ctrl()}, {24'h0, C_NORMAL});
    tick();
    chk("lu_after_stall", stall_cnt, 32'd1);

    // ex_rd = 0 never hazards
    ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1'b1;
    #3 chk("lu_x0", {24'h0, ctrl()}, {24'h0, C_NORMAL});
    tick();
    chk("lu_x0_stall", stall_cnt, 32'd1);

    // rs2 match, used vs unused
    idle(); ex_is_load = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_rs2_used = 1'b1;
    #3 chk("lu_rs2", {24'h0, ctrl()}, {24'h0, C_LU});
    tick();
    chk("lu_rs2_stall", stall_cnt, 32'd2);
    id_rs2_used = 1'b0;
    #3 chk("lu_rs2_unused", {24'h0, ctrl()}, {24'h0, C_NORMAL});
    tick();

    // redirect beats load-use, fetch valid -> stays RUN
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
    ex_redirect = 1'b1; imem_valid = 1'b1;
    #3 chk("redir_lu", {24'h0, ctrl()}, {24'h0, C_REDIR});
    tick();
    chk("redir_flush_cnt", flush_cnt, 32'd1);
    chk("redir_stall_cnt", stall_cnt, 32'd2);
    idle();
    #3 chk("redir_after", {24'h0, ctrl()}, {24'h0, C_NORMAL});
    tick();

    // dmem_wait for 3 cycles
    for (int i = 0; i < 3; i++) begin
      dmem_wait = 1'b1;
      #3 chk($sformatf("freeze_%0d", i), {24'h0, ctrl()}, {24'h0, C_FREEZE});
      tick();
      chk($sformatf("freeze_stall_%0d", i), stall_cnt, 32'd3 + 32'(i));
    end
    dmem_wait = 1'b0;
    #3 chk("mem_resume", {24'h0, ctrl()}, {24'h0, C_NORMAL});
    tick();
    chk("mem_resume_stall", stall_cnt, 32'd5);

    // redirect with fetch outstanding -> DROP
    ex_redirect = 1'b1; imem_busy = 1'b1; imem_valid = 1'b0;
    #3 chk("redir_drop", {24'h0, ctrl()}, {24'h0, C_REDIR});
    tick();
    chk("redir_drop_flush", flush_cnt, 32'd2);
    ex_redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #3 chk($sformatf("drop_idle_%0d", i), {24'h0, ctrl()}, {24'h0, C_FSTALL});
      tick();
    end
    chk("drop_stall", stall_cnt, 32'd7);
    imem_busy = 1'b0; imem_valid = 1'b1;
    #3 chk("drop_discard", {24'h0, ctrl()}, {24'h0, C_DISCRD});
    tick();
    #3 chk("drop_accept", {24'h0, ctrl()}, {24'h0, C_NORMAL});
    tick();
    chk("drop_done_stall", stall_cnt, 32'd7);

    // reset in MEM_WAIT
    dmem_wait = 1'b1;
    tick();
    chk("mw_pre_stall", stall_cnt, 32'd8);
    rst = 1'b0;
    #3 chk("mw_rst_ctrl", {24'h0, ctrl()}, {24'h0, C_RESET});
    tick();
    chk("mw_rst_stall", stall_cnt, 32'd0);
    chk("mw_rst_flush", flush_cnt, 32'd0);
    rst = 1'b1; dmem_wait = 1'b0;
    #3 chk("mw_rst_run", {24'h0, ctrl()}, {24'h0, C_NORMAL});
    tick();

    // reset in DROP forgets the pending drop
    ex_redirect = 1'b1; imem_busy = 1'b1; imem_valid = 1'b0;
    tick();
    idle(); imem_busy = 1'b1; imem_valid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1; imem_busy = 1'b0; imem_valid = 1'b1;
    #3 chk("drop_rst_run", {24'h0, ctrl()}, {24'h0, C_NORMAL});
    tick();

    // saturation on the 4-bit instance
    rst = 1'b0; idle();
    tick();
    rst = 1'b1; imem_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 14) chk("sat_reach", {28'h0, stall_cnt4}, 32'd15);
    end
    chk("sat_hold", {28'h0, stall_cnt4}, 32'd15);
    chk("sat_wide", stall_cnt, 32'd20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
